// File: rtl/ysyx_23060332_lsu_if.sv
//------------------------------------------------------------------------------
// Module  : ysyx_23060332_lsu_if
// Brief   : Bundle of the LSU's EXU handshake, data-memory bus and
//           register-file write port. The slave modport is the LSU view;
//           the master modport is the surrounding pipeline/memory view.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ysyx_23060332_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);
  // EXU -> LSU handshake
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rd;
  logic              in_rd_wen;
  logic [XLEN-1:0]   in_alu_res;
  logic [XLEN-1:0]   in_store_data;
  logic [1:0]        in_mem_op;
  logic [1:0]        in_mem_size;
  logic              in_mem_unsigned;
  // data-memory bus
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [3:0]        mem_wmask;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ack;
  // register-file write port
  logic              reg_wen;
  logic [4:0]        waddr;
  logic [XLEN-1:0]   wdata;
  logic              done;

  modport slave (
    input  in_valid, in_rd, in_rd_wen, in_alu_res, in_store_data,
           in_mem_op, in_mem_size, in_mem_unsigned,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_ack,
    output reg_wen, waddr, wdata, done
  );

  modport master (
    output in_valid, in_rd, in_rd_wen, in_alu_res, in_store_data,
           in_mem_op, in_mem_size, in_mem_unsigned,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata, mem_ack,
    input  reg_wen, waddr, wdata, done
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_23060332_lsu.sv
//------------------------------------------------------------------------------
// Module  : ysyx_23060332_lsu
// Brief   : Multi-cycle memory-access / write-back stage. Accepts one EXU
//           result, performs an optional load/store over a req/ack bus,
//           aligns/extends load data and pulses the register-file write.
//           Optional macro YSYX_23060332_LSU_MISALIGN_TRAP_EN adds a
//           misalign output and skips the bus for misaligned half/word ops.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_23060332_lsu #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_23060332_lsu_if.slave     bus
`ifdef YSYX_23060332_LSU_MISALIGN_TRAP_EN
  ,
  output logic                   misalign
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [3:0]        mem_wmask_q;
  logic              reg_wen_q;
  logic [4:0]        waddr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              done_q;
  // captured instruction attributes needed after acceptance
  logic              wen_ok_q;
  logic              is_load_q;
  logic [1:0]        addr_lo_q;
  logic [1:0]        size_q;
  logic              uns_q;

  logic              w_accept;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_mem;
  logic              w_mis;
  logic [1:0]        w_a;
  logic [3:0]        w_wmask;
  logic [XLEN-1:0]   w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load_val;

  assign w_accept   = (state_q == S_IDLE) && in_ready_q && bus.in_valid;
  assign w_is_load  = (bus.in_mem_op == 2'b01);
  assign w_is_store = (bus.in_mem_op == 2'b10);
  assign w_is_mem   = w_is_load || w_is_store;
  assign w_a        = bus.in_alu_res[1:0];

`ifdef YSYX_23060332_LSU_MISALIGN_TRAP_EN
  assign w_mis = w_is_mem &&
                 (((bus.in_mem_size == 2'b01) && w_a[0]) ||
                  (bus.in_mem_size[1] && (w_a != 2'b00)));
`else
  assign w_mis = 1'b0;
`endif

  // Store lane enables and lane-replicated write data from the incoming op
  always_comb begin
    w_wmask = 4'b1111;
    w_wdata = bus.in_store_data;
    case (bus.in_mem_size)
      2'b00: begin
        w_wmask = 4'b0001 << w_a;
        w_wdata = {4{bus.in_store_data[7:0]}};
      end
      2'b01: begin
        w_wmask = w_a[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.in_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection and sign/zero extension from captured attributes
  always_comb begin
    w_byte     = bus.mem_rdata[{addr_lo_q, 3'b000} +: 8];
    w_half     = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    w_load_val = bus.mem_rdata;
    case (size_q)
      2'b00:   w_load_val = {{24{w_byte[7] & ~uns_q}}, w_byte};
      2'b01:   w_load_val = {{16{w_half[15] & ~uns_q}}, w_half};
      default: ;
    endcase
  end

  // Control FSM; every output is a register updated here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      reg_wen_q   <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      wen_ok_q    <= 1'b0;
      is_load_q   <= 1'b0;
      addr_lo_q   <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (w_accept) begin
            in_ready_q  <= 1'b0;
            waddr_q     <= bus.in_rd;
            wdata_q     <= bus.in_alu_res;
            wen_ok_q    <= bus.in_rd_wen && (bus.in_rd != 5'd0);
            is_load_q   <= w_is_load;
            addr_lo_q   <= w_a;
            size_q      <= bus.in_mem_size;
            uns_q       <= bus.in_mem_unsigned;
            mem_addr_q  <= {bus.in_alu_res[ADDR_W-1:2], 2'b00};
            mem_wdata_q <= w_wdata;
            mem_wmask_q <= w_wmask;
            if (w_mis) begin
              state_q   <= S_WB;
              done_q    <= 1'b1;
              reg_wen_q <= 1'b0;
            end else if (w_is_mem) begin
              state_q   <= S_REQ;
              mem_req_q <= 1'b1;
              mem_we_q  <= w_is_store;
            end else begin
              state_q   <= S_WB;
              done_q    <= 1'b1;
              reg_wen_q <= bus.in_rd_wen && (bus.in_rd != 5'd0);
            end
          end
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            state_q   <= S_WB;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            reg_wen_q <= is_load_q && wen_ok_q;
            if (is_load_q) begin
              wdata_q <= w_load_val;
            end
          end
        end
        S_WB: begin
          state_q    <= S_IDLE;
          done_q     <= 1'b0;
          reg_wen_q  <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= S_IDLE;
          mem_req_q  <= 1'b0;
          mem_we_q   <= 1'b0;
          done_q     <= 1'b0;
          reg_wen_q  <= 1'b0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef YSYX_23060332_LSU_MISALIGN_TRAP_EN
  logic misalign_q;

  // Misalign flag is high only during the write-back of a trapped access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= w_accept && w_mis;
    end
  end

  assign misalign = misalign_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.reg_wen   = reg_wen_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060332_lsu.sv
//------------------------------------------------------------------------------
// Module  : tb_ysyx_23060332_lsu
// Brief   : Self-checking bench for ysyx_23060332_lsu: directed scenarios
//           plus randomized instructions checked against an arithmetic
//           reference model of the load/store rules.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_23060332_lsu;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  ysyx_23060332_lsu_if bus ();

`ifdef YSYX_23060332_LSU_MISALIGN_TRAP_EN
  logic misalign;
  localparam bit c_TRAP = 1'b1;
`else
  localparam bit c_TRAP = 1'b0;
`endif

  ysyx_23060332_lsu u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef YSYX_23060332_LSU_MISALIGN_TRAP_EN
    ,
    .misalign (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] addr,
                                         input logic [1:0] sz, input logic uns);
    int unsigned a = addr % 4;
    int unsigned v;
    if (sz == 2'd0) begin
      v = (rdata >> (8 * a)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rdata >> ((a >= 2) ? 16 : 0)) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_mask(input logic [31:0] addr, input logic [1:0] sz);
    int unsigned a = addr % 4;
    if (sz == 2'd0) return 4'(1 << a);
    if (sz == 2'd1) return (a >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_sdata(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit m_mis(input logic [31:0] addr, input logic [1:0] op, input logic [1:0] sz);
    bit is_mem = (op == 2'd1) || (op == 2'd2);
    if (!c_TRAP || !is_mem) return 1'b0;
    if (sz == 2'd1) return (addr % 2) != 0;
    if (sz >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    if (t >= 20) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  // Issue one instruction and check bus activity and write-back against the model
  task automatic run_op(input logic [4:0] rd, input logic wen, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [1:0] op, input logic [1:0] sz,
                        input logic uns, input int k, input logic [31:0] rdata);
    bit          is_mem;
    bit          mis;
    bit          exp_wen;
    logic [31:0] exp_wd;
    wait_ready();
    bus.in_valid        = 1'b1;
    bus.in_rd           = rd;
    bus.in_rd_wen       = wen;
    bus.in_alu_res      = alu;
    bus.in_store_data   = sd;
    bus.in_mem_op       = op;
    bus.in_mem_size     = sz;
    bus.in_mem_unsigned = uns;
    step();
    bus.in_valid      = 1'b0;
    bus.in_alu_res    = $urandom;
    bus.in_store_data = $urandom;
    is_mem  = (op == 2'd1) || (op == 2'd2);
    mis     = m_mis(alu, op, sz);
    exp_wen = !mis && wen && (rd != 0) && (op != 2'd2);
    exp_wd  = (op == 2'd1) ? m_load(rdata, alu, sz, uns) : alu;
    if (is_mem && !mis) begin
      for (int i = 0; i <= k; i++) begin
        chk("mem_req_held", 32'(bus.mem_req), 32'd1);
        chk("mem_addr", bus.mem_addr, alu & 32'hFFFF_FFFC);
        chk("mem_we", 32'(bus.mem_we), 32'(op == 2'd2));
        if (op == 2'd2) begin
          chk("mem_wmask", 32'(bus.mem_wmask), 32'(m_mask(alu, sz)));
          chk("mem_wdata", bus.mem_wdata, m_sdata(sd, sz));
        end
        chk("done_in_req", 32'(bus.done), 32'd0);
        if (i == k) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdata;
        end
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
      end
    end else begin
      chk("no_mem_req", 32'(bus.mem_req), 32'd0);
    end
    // write-back cycle
    chk("wb_done", 32'(bus.done), 32'd1);
    chk("wb_reg_wen", 32'(bus.reg_wen), 32'(exp_wen));
    chk("wb_in_ready", 32'(bus.in_ready), 32'd0);
    chk("wb_mem_req", 32'(bus.mem_req), 32'd0);
`ifdef YSYX_23060332_LSU_MISALIGN_TRAP_EN
    chk("wb_misalign", 32'(misalign), 32'(mis));
`endif
    if (exp_wen) begin
      chk("wb_waddr", 32'(bus.waddr), 32'(rd));
      chk("wb_wdata", bus.wdata, exp_wd);
    end
    step();
    chk("post_done", 32'(bus.done), 32'd0);
    chk("post_reg_wen", 32'(bus.reg_wen), 32'd0);
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef YSYX_23060332_LSU_MISALIGN_TRAP_EN
    chk("post_misalign", 32'(misalign), 32'd0);
`endif
  endtask

  initial begin
    n_chk               = 0;
    n_pass              = 0;
    rst                 = 1'b0;
    bus.in_valid        = 1'b0;
    bus.in_rd           = '0;
    bus.in_rd_wen       = 1'b0;
    bus.in_alu_res      = '0;
    bus.in_store_data   = '0;
    bus.in_mem_op       = '0;
    bus.in_mem_size     = '0;
    bus.in_mem_unsigned = 1'b0;
    bus.mem_rdata       = '0;
    bus.mem_ack         = 1'b0;
    step();
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_reg_wen", 32'(bus.reg_wen), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    #3 rst = 1'b1;
    step();
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // directed scenarios
    run_op(5'd5, 1'b1, 32'h0000_1234, 32'd0, 2'd0, 2'd2, 1'b0, 0, 32'd0);
    run_op(5'd0, 1'b1, 32'h0000_1234, 32'd0, 2'd0, 2'd2, 1'b0, 0, 32'd0);
    run_op(5'd7, 1'b1, 32'h0000_1003, 32'd0, 2'd1, 2'd0, 1'b0, 3, 32'h80FF_FFFF);
    run_op(5'd7, 1'b1, 32'h0000_1003, 32'd0, 2'd1, 2'd0, 1'b1, 3, 32'h80FF_FFFF);
    run_op(5'd9, 1'b1, 32'h0000_2002, 32'hAAAA_5678, 2'd2, 2'd1, 1'b0, 1, 32'd0);
    run_op(5'd3, 1'b1, 32'h0000_3000, 32'd0, 2'd1, 2'd2, 1'b0, 0, 32'hDEAD_BEEF);
    run_op(5'd4, 1'b1, 32'h0000_3002, 32'd0, 2'd1, 2'd2, 1'b0, 0, 32'h1357_9BDF);
    run_op(5'd6, 1'b1, 32'h0000_4001, 32'd0, 2'd1, 2'd3, 1'b1, 2, 32'hCAFE_F00D);
    run_op(5'd8, 1'b1, 32'h0000_5555, 32'd0, 2'd3, 2'd1, 1'b0, 0, 32'd0);

    // back-to-back acceptance with in_valid held high
    wait_ready();
    bus.in_valid        = 1'b1;
    bus.in_rd           = 5'd10;
    bus.in_rd_wen       = 1'b1;
    bus.in_alu_res      = 32'h0000_3000;
    bus.in_mem_op       = 2'd1;
    bus.in_mem_size     = 2'd2;
    bus.in_mem_unsigned = 1'b0;
    step();
    chk("b2b_req1", 32'(bus.mem_req), 32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    step();
    bus.mem_ack = 1'b0;
    chk("b2b_wb1", 32'(bus.done), 32'd1);
    chk("b2b_wd1", bus.wdata, 32'h0BAD_F00D);
    step();
    chk("b2b_idle_ready", 32'(bus.in_ready), 32'd1);
    chk("b2b_idle_req", 32'(bus.mem_req), 32'd0);
    step();
    chk("b2b_req2", 32'(bus.mem_req), 32'd1);
    chk("b2b_ready2", 32'(bus.in_ready), 32'd0);
    bus.in_valid  = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    step();
    bus.mem_ack = 1'b0;
    chk("b2b_wd2", bus.wdata, 32'h1111_2222);
    step();

    // reset in the middle of a memory request
    wait_ready();
    bus.in_valid   = 1'b1;
    bus.in_rd      = 5'd12;
    bus.in_rd_wen  = 1'b1;
    bus.in_alu_res = 32'h0000_6000;
    bus.in_mem_op  = 2'd1;
    bus.in_mem_size = 2'd2;
    step();
    bus.in_valid = 1'b0;
    chk("mid_req", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("arst_reg_wen", 32'(bus.reg_wen), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    #3 rst = 1'b1;
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
      chk("post_rst_wen", 32'(bus.reg_wen), 32'd0);
      chk("post_rst_done", 32'(bus.done), 32'd0);
      step();
    end

    // randomized instructions
    for (int n = 0; n < 300; n++) begin
      logic [4:0] r_rd;
      r_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      run_op(r_rd, 1'($urandom), $urandom, $urandom, 2'($urandom), 2'($urandom),
             1'($urandom), int'($urandom_range(0, 3)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
